instr_encoder: RTL and testbench

Encodes ALU-level micro-op requests (op, ssel, rs1/rs2/rdst IDs, imm) into 32-bit MIPS machine words using the team's ALU op encoding, so that decoding the emitted word reproduces the request. It converts a program stream into instructions for instruction-memory preload or testbench stimulus. The block has a start/last/done program frame, a ready/valid input, and a small output FIFO with ready/valid output. Each emitted word carries its byte address.

---
 rtl/instr_encoder_pkg.sv | 35 +++
 rtl/instr_encoder_if.sv | 34 +++
 rtl/instr_encoder_fifo.sv | 56 +++++
 rtl/instr_encoder.sv | 139 +++++++++++++
 tb/tb_instr_encoder.sv | 217 +++++++++++++++++++++
 5 files changed

// File: rtl/instr_encoder_pkg.sv
// instr_encoder_pkg: shared constants for the MIPS instruction encoder.
//   - ALU op codes (same values the decoder uses)
//   - MIPS primary opcodes and R-type funct codes
//   - encoder FSM state encoding
package instr_encoder_pkg;

    // ALU op encoding
    localparam logic [3:0] OP_AND         = 4'b0000;
    localparam logic [3:0] OP_OR          = 4'b0001;
    localparam logic [3:0] OP_ADD         = 4'b0010;
    localparam logic [3:0] OP_SUB         = 4'b0110;
    localparam logic [3:0] OP_SLT         = 4'b0111;
    localparam logic [3:0] OP_NOR         = 4'b1100;
    localparam logic [3:0] OP_NOT_DEFINED = 4'b1111;

    // MIPS primary opcodes
    localparam logic [5:0] OPC_R    = 6'b000000;
    localparam logic [5:0] OPC_ADDI = 6'b001000;
    localparam logic [5:0] OPC_SLTI = 6'b001010;

    // R-type funct codes
    localparam logic [5:0] FN_ADD = 6'b100000;
    localparam logic [5:0] FN_SUB = 6'b100010;
    localparam logic [5:0] FN_AND = 6'b100100;
    localparam logic [5:0] FN_OR  = 6'b100101;
    localparam logic [5:0] FN_NOR = 6'b100111;
    localparam logic [5:0] FN_SLT = 6'b101010;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2
    } state_e;

endpackage

// File: rtl/instr_encoder_if.sv
// instr_encoder_if: request (ready/valid) and output (ready/valid) channels
// of the instruction encoder.
//   master : request producer / output consumer (testbench, program loader)
//   slave  : the encoder itself
interface instr_encoder_if #(
    parameter int DWIDTH = 32,
    parameter int AWIDTH = 32
);
    logic              req_valid;
    logic              req_ready;
    logic              req_last;
    logic [3:0]        req_op;
    logic              req_ssel;
    logic [4:0]        req_rs1_id;
    logic [4:0]        req_rs2_id;
    logic [4:0]        req_rdst_id;
    logic [DWIDTH-1:0] req_imm;
    logic              out_valid;
    logic              out_ready;
    logic [DWIDTH-1:0] out_instr;
    logic [AWIDTH-1:0] out_addr;

    modport master (
        output req_valid, req_last, req_op, req_ssel, req_rs1_id, req_rs2_id,
               req_rdst_id, req_imm, out_ready,
        input  req_ready, out_valid, out_instr, out_addr
    );

    modport slave (
        input  req_valid, req_last, req_op, req_ssel, req_rs1_id, req_rs2_id,
               req_rdst_id, req_imm, out_ready,
        output req_ready, out_valid, out_instr, out_addr
    );
endinterface

// File: rtl/instr_encoder_fifo.sv
// instr_fifo: synchronous DEPTH x WIDTH FIFO, synchronous active-high reset.
//   push_i/din_i : write (ignored when full)
//   pop_i        : read advance (ignored when empty)
//   dout_o       : head entry, zero while empty
//   full_o/empty_o/count_o : occupancy
module instr_fifo #(
    parameter int DEPTH = 2,
    parameter int WIDTH = 64
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push_i,
    input  logic [WIDTH-1:0]         din_i,
    input  logic                     pop_i,
    output logic [WIDTH-1:0]         dout_o,
    output logic                     full_o,
    output logic                     empty_o,
    output logic [$clog2(DEPTH):0]   count_o
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PW-1:0]    wr_ptr_q, rd_ptr_q;
    logic [CW-1:0]    count_q;
    logic             do_push, do_pop;

    assign full_o  = (count_q == CW'(DEPTH));
    assign empty_o = (count_q == '0);
    assign count_o = count_q;
    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;
    // Masked head keeps the output bus at zero after reset / when drained.
    assign dout_o  = empty_o ? '0 : mem_q[rd_ptr_q];

    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= din_i;
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end
endmodule

// File: rtl/instr_encoder.sv
// instr_encoder: turns ALU micro-op requests into 32-bit MIPS words tagged
// with byte addresses, framed by start / req_last / done.
//   clk, rst        : clock, synchronous active-high reset
//   start/base_addr : open a frame (IDLE only), base_addr seeds the address
//   bus (slave)     : request ready/valid in, encoded word ready/valid out
//   err_pulse       : one cycle after an illegal request is consumed
//   err_cnt         : saturating illegal-request count
//   done            : one-cycle pulse once the frame has fully drained
module instr_encoder
    import instr_encoder_pkg::*;
#(
    parameter int DWIDTH = 32,
    parameter int AWIDTH = 32,
    parameter int DEPTH  = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [AWIDTH-1:0] base_addr,
    instr_encoder_if.slave    bus,
    output logic              err_pulse,
    output logic [7:0]        err_cnt,
    output logic              done
);
    localparam int CW = $clog2(DEPTH) + 1;

    state_e             state_q, state_d;
    logic [AWIDTH-1:0]  addr_q;
    logic               err_pulse_q;
    logic [7:0]         err_cnt_q;

    logic [DWIDTH-1:0]  word;
    logic               legal;
    logic [5:0]         funct, i_opc;
    logic               r_ok, i_ok, imm_fits;
    logic               accept, push;

    logic [DWIDTH-1:0]  fifo_instr;
    logic [AWIDTH-1:0]  fifo_addr;
    logic               fifo_full, fifo_empty;
    logic [CW-1:0]      fifo_cnt;

    // Encoding and legality
    always_comb begin
        funct = 6'b0;
        r_ok  = 1'b1;
        case (bus.req_op)
            OP_ADD:  funct = FN_ADD;
            OP_SUB:  funct = FN_SUB;
            OP_AND:  funct = FN_AND;
            OP_OR:   funct = FN_OR;
            OP_NOR:  funct = FN_NOR;
            OP_SLT:  funct = FN_SLT;
            default: r_ok  = 1'b0;
        endcase

        i_opc = OPC_ADDI;
        i_ok  = 1'b1;
        case (bus.req_op)
            OP_ADD:  i_opc = OPC_ADDI;
            OP_SLT:  i_opc = OPC_SLTI;
            default: i_ok  = 1'b0;
        endcase

        // Bits 31..15 all equal <=> value fits a signed 16-bit field.
        imm_fits = (&bus.req_imm[DWIDTH-1:15]) || !(|bus.req_imm[DWIDTH-1:15]);

        if (bus.req_ssel) begin
            legal = r_ok;
            word  = {OPC_R, bus.req_rs1_id, bus.req_rs2_id, bus.req_rdst_id,
                     5'b0, funct};
        end else begin
            legal = i_ok && imm_fits;
            word  = {i_opc, bus.req_rs1_id, bus.req_rdst_id, bus.req_imm[15:0]};
        end
    end

    // Only a free slot opens the input; a same-cycle pop does not count.
    assign bus.req_ready = !rst && (state_q == ST_RUN) && !fifo_full;
    assign accept        = bus.req_valid && bus.req_ready;
    assign push          = accept && legal;

    // FSM
    always_ff @(posedge clk) begin
        if (rst) state_q <= ST_IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        done    = 1'b0;
        case (state_q)
            ST_IDLE:  if (start) state_d = ST_RUN;
            ST_RUN:   if (accept && bus.req_last) state_d = ST_DRAIN;
            ST_DRAIN: if (fifo_cnt == '0) begin
                          state_d = ST_IDLE;
                          done    = !rst;
                      end
            default:  state_d = ST_IDLE;
        endcase
    end

    // Address counter and error reporting
    always_ff @(posedge clk) begin
        if (rst) begin
            addr_q      <= '0;
            err_pulse_q <= 1'b0;
            err_cnt_q   <= '0;
        end else begin
            if (state_q == ST_IDLE && start) addr_q <= base_addr;
            else if (push)                   addr_q <= addr_q + AWIDTH'(4);
            err_pulse_q <= accept && !legal;
            if (accept && !legal && err_cnt_q != 8'hFF)
                err_cnt_q <= err_cnt_q + 8'd1;
        end
    end

    assign err_pulse = err_pulse_q;
    assign err_cnt   = err_cnt_q;

    instr_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (DWIDTH + AWIDTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push_i  (push),
        .din_i   ({word, addr_q}),
        .pop_i   (bus.out_valid && bus.out_ready),
        .dout_o  ({fifo_instr, fifo_addr}),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .count_o (fifo_cnt)
    );

    assign bus.out_valid = !fifo_empty;
    assign bus.out_instr = fifo_instr;
    assign bus.out_addr  = fifo_addr;
endmodule

// File: tb/tb_instr_encoder.sv
module tb_instr_encoder;
    import instr_encoder_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [31:0] base_addr;
    logic        err_pulse;
    logic [7:0]  err_cnt;
    logic        done;

    int n_chk = 0;
    int n_err = 0;
    int done_seen = 0;
    int err_seen = 0;
    logic [31:0] qi[$];
    logic [31:0] qa[$];

    instr_encoder_if #(.DWIDTH(32), .AWIDTH(32)) bus ();

    instr_encoder #(.DWIDTH(32), .AWIDTH(32), .DEPTH(2)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .base_addr (base_addr),
        .bus       (bus),
        .err_pulse (err_pulse),
        .err_cnt   (err_cnt),
        .done      (done)
    );

    always #5 clk = ~clk;

    // Output/event monitor on the inactive edge
    always @(negedge clk) begin
        if (!rst) begin
            if (bus.out_valid && bus.out_ready) begin
                qi.push_back(bus.out_instr);
                qa.push_back(bus.out_addr);
            end
            if (done)      done_seen++;
            if (err_pulse) err_seen++;
        end
    end

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [3:0] op, input logic ssel, input logic [4:0] rs1,
                        input logic [4:0] rs2, input logic [4:0] rd,
                        input logic [31:0] imm, input logic last);
        bit ok = 0;
        bus.req_op = op; bus.req_ssel = ssel; bus.req_rs1_id = rs1;
        bus.req_rs2_id = rs2; bus.req_rdst_id = rd; bus.req_imm = imm;
        bus.req_last = last; bus.req_valid = 1'b1;
        for (int i = 0; i < 50 && !ok; i++) begin
            if (bus.req_ready) ok = 1;
            tick();
        end
        bus.req_valid = 1'b0;
        bus.req_last  = 1'b0;
        if (!ok) chk("send_timeout", 0, 1);
    endtask

    task automatic open_frame(input logic [31:0] base);
        base_addr = base; start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic wait_done(input string tag);
        bit ok = 0;
        for (int i = 0; i < 60 && !ok; i++) begin
            if (done) ok = 1;
            tick();
        end
        chk(tag, ok, 1);
    endtask

    task automatic chk_word(input string tag, input int idx, input logic [31:0] instr,
                            input logic [31:0] addr);
        if (idx < qi.size()) begin
            chk($sformatf("%s_instr%0d", tag, idx), qi[idx], instr);
            chk($sformatf("%s_addr%0d", tag, idx), qa[idx], addr);
        end else begin
            chk($sformatf("%s_missing%0d", tag, idx), 0, 1);
        end
    endtask

    initial begin
        int d0;
        rst = 1'b1; start = 1'b0; base_addr = '0;
        bus.req_valid = 0; bus.req_last = 0; bus.req_op = '0; bus.req_ssel = 0;
        bus.req_rs1_id = '0; bus.req_rs2_id = '0; bus.req_rdst_id = '0;
        bus.req_imm = '0; bus.out_ready = 0;
        tick(); tick();
        chk("rst_req_ready", bus.req_ready, 0);
        chk("rst_out_valid", bus.out_valid, 0);
        chk("rst_out_instr", bus.out_instr, 0);
        chk("rst_out_addr",  bus.out_addr, 0);
        chk("rst_err_pulse", err_pulse, 0);
        chk("rst_err_cnt",   err_cnt, 0);
        chk("rst_done",      done, 0);
        rst = 1'b0;
        tick();

        // 1: single add, latency 1, done after drain
        open_frame(32'h40);
        chk("t1_ready", bus.req_ready, 1);
        send(OP_ADD, 1, 5'd1, 5'd2, 5'd3, 32'h0, 1);
        chk("t1_valid", bus.out_valid, 1);
        chk("t1_instr", bus.out_instr, 32'h0022_1820);
        chk("t1_addr",  bus.out_addr, 32'h40);
        bus.out_ready = 1;
        tick();
        chk("t1_done", done, 1);
        tick();
        chk("t1_done_low", done, 0);
        chk("t1_idle", dut.state_q, ST_IDLE);
        chk("t1_count", qi.size(), 1);

        // 2: mixed I/R frame streaming
        qi.delete(); qa.delete();
        open_frame(32'h0);
        send(OP_ADD, 0, 5'd4, 5'd0, 5'd5, 32'hFFFF_FFFF, 0);
        send(OP_SLT, 0, 5'd1, 5'd0, 5'd2, 32'd5, 0);
        send(OP_NOR, 1, 5'd5, 5'd6, 5'd7, 32'h0, 1);
        wait_done("t2_done");
        chk_word("t2", 0, 32'h2085_FFFF, 32'h0);
        chk_word("t2", 1, 32'h2822_0005, 32'h4);
        chk_word("t2", 2, 32'h00A6_3827, 32'h8);

        // 3: backpressure with a full FIFO
        qi.delete(); qa.delete();
        bus.out_ready = 0;
        open_frame(32'h100);
        send(OP_AND, 1, 5'd2, 5'd3, 5'd1, 32'h0, 0);
        send(OP_OR,  1, 5'd5, 5'd6, 5'd4, 32'h0, 0);
        chk("t3_full_ready", bus.req_ready, 0);
        bus.req_op = OP_SUB; bus.req_ssel = 1; bus.req_rs1_id = 5'd8;
        bus.req_rs2_id = 5'd9; bus.req_rdst_id = 5'd7; bus.req_valid = 1;
        for (int i = 0; i < 2; i++) begin
            tick();
            chk("t3_hold_instr", bus.out_instr, 32'h0043_0824);
            chk("t3_hold_addr",  bus.out_addr, 32'h100);
            chk("t3_hold_ready", bus.req_ready, 0);
        end
        bus.out_ready = 1;
        send(OP_SUB, 1, 5'd8, 5'd9, 5'd7, 32'h0, 1);
        wait_done("t3_done");
        chk_word("t3", 0, 32'h0043_0824, 32'h100);
        chk_word("t3", 1, 32'h00A6_2025, 32'h104);
        chk_word("t3", 2, 32'h0109_3822, 32'h108);

        // 4: illegal requests
        qi.delete(); qa.delete();
        err_seen = 0;
        open_frame(32'h200);
        send(OP_OR, 0, 5'd1, 5'd0, 5'd2, 32'd3, 0);
        chk("t4_pulse1", err_pulse, 1);
        chk("t4_novalid1", bus.out_valid, 0);
        send(OP_ADD, 0, 5'd1, 5'd0, 5'd2, 32'h0000_8000, 0);
        chk("t4_pulse2", err_pulse, 1);
        chk("t4_novalid2", bus.out_valid, 0);
        send(OP_ADD, 0, 5'd1, 5'd0, 5'd3, 32'h0000_7FFF, 1);
        chk("t4_pulse_clr", err_pulse, 0);
        chk("t4_err_cnt", err_cnt, 8'd2);
        chk("t4_err_seen", err_seen, 2);
        wait_done("t4_done");
        chk("t4_count", qi.size(), 1);
        chk_word("t4", 0, 32'h2023_7FFF, 32'h200);

        // 5: reset mid-frame, start ignored while running
        bus.out_ready = 0;
        open_frame(32'h300);
        send(OP_ADD, 1, 5'd1, 5'd2, 5'd3, 32'h0, 0);
        send(OP_SUB, 1, 5'd1, 5'd2, 5'd3, 32'h0, 0);
        base_addr = 32'h500; start = 1;
        tick();
        start = 0;
        chk("t5_start_ignored", dut.state_q, ST_RUN);
        chk("t5_fifo_full", bus.req_ready, 0);
        d0 = done_seen;
        rst = 1;
        tick();
        rst = 0;
        chk("t5_out_valid", bus.out_valid, 0);
        chk("t5_req_ready", bus.req_ready, 0);
        chk("t5_idle", dut.state_q, ST_IDLE);
        chk("t5_err_cnt", err_cnt, 0);
        tick(); tick();
        chk("t5_no_done", done_seen, d0);

        // 6: address wrap
        qi.delete(); qa.delete();
        bus.out_ready = 1;
        open_frame(32'hFFFF_FFFC);
        send(OP_ADD, 1, 5'd1, 5'd2, 5'd3, 32'h0, 0);
        send(OP_SUB, 1, 5'd8, 5'd9, 5'd7, 32'h0, 1);
        wait_done("t6_done");
        chk_word("t6", 0, 32'h0022_1820, 32'hFFFF_FFFC);
        chk_word("t6", 1, 32'h0109_3822, 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end
endmodule
